// File: rtl/systolic_feeder.sv
// Input skew stage for an N x N systolic PE array: buffers A by rows and B by columns,
// then streams them diagonally skewed with zero padding for FEED_LEN = 3N-2 cycles.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_wr_en,
  input  logic [$clog2(N)-1:0]    a_wr_idx,
  input  logic [DATA_WIDTH*N-1:0] a_wr_data,
  input  logic                    b_wr_en,
  input  logic [$clog2(N)-1:0]    b_wr_idx,
  input  logic [DATA_WIDTH*N-1:0] b_wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH*N-1:0] a_out,
  output logic [DATA_WIDTH*N-1:0] b_out,
  output logic                    we_out
);

  localparam int FEED_LEN = 3*N - 2;
  localparam int TW       = $clog2(FEED_LEN);
  localparam int IW       = $clog2(N);

  typedef enum logic {IDLE, FEED} state_t;

  state_t                  state, state_next;
  logic [TW-1:0]           t, t_next;
  logic                    feed_active;
  logic                    busy_next, done_next, we_next;
  logic [DATA_WIDTH*N-1:0] a_next, b_next;
  logic [TW-1:0]           k;
  logic                    wr_ok;

  // a_buf[i][k] = A[i][k]; b_buf[j][k] = B[k][j]
  logic [DATA_WIDTH-1:0] a_buf [N][N];
  logic [DATA_WIDTH-1:0] b_buf [N][N];

  assign wr_ok = (state == IDLE) && !start;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
      end
    end else if (wr_ok) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (a_wr_en) a_buf[a_wr_idx][j] <= a_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        if (b_wr_en) b_buf[b_wr_idx][j] <= b_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_next  = state;
    t_next      = t;
    feed_active = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    we_next     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = FEED;
          t_next      = '0;
          feed_active = 1'b1;
          busy_next   = 1'b1;
          we_next     = 1'b1;
        end
      end
      FEED: begin
        if (t == TW'(FEED_LEN - 1)) begin
          state_next = IDLE;
          t_next     = '0;
          done_next  = 1'b1;
        end else begin
          t_next      = t + 1'b1;
          feed_active = 1'b1;
          busy_next   = 1'b1;
          we_next     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane i carries element t-i of its row/column; k wraps when t < i, hence the lower bound test.
  always_comb begin
    a_next = '0;
    b_next = '0;
    k      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = t_next - TW'(i);
      if (feed_active && (t_next >= TW'(i)) && (k < TW'(N))) begin
        a_next[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][k[IW-1:0]];
        b_next[i*DATA_WIDTH +: DATA_WIDTH] = b_buf[i][k[IW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_out <= 1'b0;
      a_out  <= '0;
      b_out  <= '0;
    end else begin
      state  <= state_next;
      t      <= t_next;
      busy   <= busy_next;
      done   <= done_next;
      we_out <= we_next;
      a_out  <= a_next;
      b_out  <= b_next;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4, DATA_WIDTH=8).
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_wr_en, b_wr_en, start;
  logic [1:0]  a_wr_idx, b_wr_idx;
  logic [31:0] a_wr_data, b_wr_data;
  logic        busy, done, we_out;
  logic [31:0] a_out, b_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0] ma [4][4];  // ma[i][k] = A[i][k]
  logic [7:0] mb [4][4];  // mb[k][j] = B[k][j]

  systolic_feeder #(.DATA_WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wr_en(a_wr_en), .a_wr_idx(a_wr_idx), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_idx(b_wr_idx), .b_wr_data(b_wr_data),
    .start(start), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input int t);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) r[i*8 +: 8] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [31:0] exp_b(input int t);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) r[j*8 +: 8] = mb[t-j][j];
    return r;
  endfunction

  // Hand-derived A stream for A = 1..16 by rows.
  function automatic logic [31:0] ref_a(input int t);
    case (t)
      0: return 32'h00000001;
      1: return 32'h00000502;
      2: return 32'h00090603;
      3: return 32'h0D0A0704;
      4: return 32'h0E0B0800;
      5: return 32'h0F0C0000;
      6: return 32'h10000000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic write_a(input int i, input logic [31:0] d);
    a_wr_en = 1'b1; a_wr_idx = 2'(i); a_wr_data = d;
    tick();
    a_wr_en = 1'b0;
    for (int k = 0; k < 4; k++) ma[i][k] = d[k*8 +: 8];
  endtask

  task automatic write_b(input int j, input logic [31:0] d);
    b_wr_en = 1'b1; b_wr_idx = 2'(j); b_wr_data = d;
    tick();
    b_wr_en = 1'b0;
    for (int k = 0; k < 4; k++) mb[k][j] = d[k*8 +: 8];
  endtask

  // One start pulse and the full 10-cycle stream. restart_t: cycle at which start is pulsed
  // again mid-feed; wr_t: cycle of a mid-feed A write, -1 = write together with start.
  task automatic run_feed(input string tag, input bit use_ref, input int restart_t, input int wr_t);
    start = 1'b1;
    if (wr_t == -1) begin
      a_wr_en = 1'b1; a_wr_idx = 2'd1; a_wr_data = 32'hAAAAAAAA;
    end
    tick();
    start = 1'b0; a_wr_en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check($sformatf("%s_we_t%0d", tag, t), {31'b0, we_out}, 32'd1);
      check($sformatf("%s_busy_t%0d", tag, t), {31'b0, busy}, 32'd1);
      check($sformatf("%s_done_t%0d", tag, t), {31'b0, done}, 32'd0);
      check($sformatf("%s_a_t%0d", tag, t), a_out, exp_a(t));
      check($sformatf("%s_b_t%0d", tag, t), b_out, exp_b(t));
      if (use_ref) begin
        check($sformatf("%s_aref_t%0d", tag, t), a_out, ref_a(t));
        check($sformatf("%s_bref_t%0d", tag, t), b_out,
              (t % 2 == 0 && t < 8) ? (32'd1 << (4*t)) : 32'd0);
      end
      start = (t == restart_t);
      if (t == wr_t) begin
        a_wr_en = 1'b1; a_wr_idx = 2'd0; a_wr_data = 32'h09090909;
      end else a_wr_en = 1'b0;
      tick();
    end
    start = 1'b0; a_wr_en = 1'b0;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_we_end"}, {31'b0, we_out}, 32'd0);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    check({tag, "_a_end"}, a_out, 32'd0);
    check({tag, "_b_end"}, b_out, 32'd0);
    tick();
    check({tag, "_done_once"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [24:0] we_seen;
    int          dones;
    bit          drained;

    rst_n = 1'b1; start = 1'b0;
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    a_wr_idx = '0; b_wr_idx = '0; a_wr_data = '0; b_wr_data = '0;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) begin ma[i][k] = '0; mb[i][k] = '0; end
    tick(); tick();
    check("rst_we", {31'b0, we_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_a", a_out, 32'd0);
    check("rst_b", b_out, 32'd0);
    rst_n = 1'b0;
    tick();

    // A rows 1..16, B identity; A row and B column written in the same cycle once
    a_wr_en = 1'b1; a_wr_idx = 2'd0; a_wr_data = 32'h04030201;
    b_wr_en = 1'b1; b_wr_idx = 2'd0; b_wr_data = 32'h00000001;
    tick();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[0][2] = 8'd3; ma[0][3] = 8'd4;
    mb[0][0] = 8'd1;
    write_a(1, 32'h08070605);
    write_a(2, 32'h0C0B0A09);
    write_a(3, 32'h100F0E0D);
    write_b(1, 32'h00000100);
    write_b(2, 32'h00010000);
    write_b(3, 32'h01000000);

    run_feed("basic", 1'b1, -5, -5);
    run_feed("midfeed", 1'b0, 4, 2);
    run_feed("replay", 1'b1, -5, -5);
    run_feed("wr_with_start", 1'b1, -5, -1);
    run_feed("wr_replay", 1'b1, -5, -5);

    // start held: feeds at edges 0, 11, 22; we low only on the done edges 10 and 21
    start = 1'b1;
    dones = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      we_seen[e] = we_out;
      if (done) dones++;
      if (e == 11) check("hold_a_feed2_t0", a_out, exp_a(0));
    end
    start = 1'b0;
    check("hold_we_pattern", {7'b0, we_seen}, {7'b0, 25'h1FFFFFF & ~(25'd1 << 10) & ~(25'd1 << 21)});
    check("hold_dones", 32'(dones), 32'd2);
    drained = 1'b0;
    for (int e = 0; e < 20 && !drained; e++) begin
      tick();
      if (done) drained = 1'b1;
    end
    check("hold_drain", {31'b0, drained}, 32'd1);
    tick();

    // reset at t=5 of a feed
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    check("pre_rst_we", {31'b0, we_out}, 32'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_we", {31'b0, we_out}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_a", a_out, 32'd0);
    check("midrst_b", b_out, 32'd0);
    tick();
    check("midrst_no_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) begin ma[i][k] = '0; mb[i][k] = '0; end
    run_feed("cleared", 1'b0, -5, -5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
